// File: rtl/mole_game_core.sv
// Whack-a-mole game core: switch toggle detection, pseudo-random mole placement,
// score keeping and a per-second countdown.
module mole_game_core #(
   parameter int unsigned N_HOLES     = 16,
   parameter int unsigned SEC_DIV     = 100000000,
   parameter int unsigned GAME_SECS   = 30,
   parameter int unsigned MOLE_CYCLES = 150000000,
   parameter int unsigned SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               penalty_en,
   input  logic [N_HOLES-1:0] sw,
   output logic [N_HOLES-1:0] LED,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         time_left,
   output logic               playing,
   output logic               game_over
);

   localparam int unsigned IDX_W  = $clog2(N_HOLES);
   localparam int unsigned SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
   localparam int unsigned MOLE_W = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [N_HOLES-1:0] LED_ONE   = N_HOLES'(1);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t             state_q, state_d;
   logic [N_HOLES-1:0] sw_meta, sw_sync, sw_hist, toggle;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_new;
   logic [N_HOLES-1:0] led_q, led_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         time_q, time_d;
   logic [SEC_W-1:0]   sec_q, sec_d;
   logic [MOLE_W-1:0]  mole_q, mole_d;
   logic               pen_q, pen_d;
   logic               playing_q, over_q;
   logic               hit, miss, sec_wrap, mole_expire;

   // Synchronizer and history run through reset so history always equals synced sw.
   always_ff @(posedge clk) begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_hist <= sw_sync;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         lfsr_q    <= 16'hACE1;
         idx_q     <= '0;
         led_q     <= '0;
         score_q   <= '0;
         time_q    <= 8'(GAME_SECS);
         sec_q     <= '0;
         mole_q    <= '0;
         pen_q     <= 1'b0;
         playing_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         idx_q     <= idx_d;
         led_q     <= led_d;
         score_q   <= score_d;
         time_q    <= time_d;
         sec_q     <= sec_d;
         mole_q    <= mole_d;
         pen_q     <= pen_d;
         playing_q <= (state_d == PLAY);
         over_q    <= (state_d == OVER);
      end
   end

   always_comb begin
      toggle      = sw_sync ^ sw_hist;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      idx_new     = (lfsr_q[IDX_W-1:0] == idx_q) ? idx_q + IDX_W'(1) : lfsr_q[IDX_W-1:0];
      hit         = (state_q == PLAY) && (|(toggle & led_q));
      miss        = (state_q == PLAY) && !hit && (|(toggle & ~led_q));
      sec_wrap    = (sec_q == SEC_W'(SEC_DIV - 1));
      mole_expire = (mole_q == MOLE_W'(MOLE_CYCLES - 1));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      led_d   = led_q;
      score_d = score_q;
      time_d  = time_q;
      sec_d   = sec_q;
      mole_d  = mole_q;
      pen_d   = pen_q;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = PLAY;
               score_d = '0;
               time_d  = 8'(GAME_SECS);
               sec_d   = '0;
               mole_d  = '0;
               pen_d   = penalty_en;
               idx_d   = idx_new;
               led_d   = LED_ONE << idx_new;
            end
         end
         PLAY: begin
            if (hit) begin
               if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
            end else if (miss && pen_q) begin
               if (score_q != '0) score_d = score_q - SCORE_W'(1);
            end
            if (hit || mole_expire) begin
               idx_d  = idx_new;
               led_d  = LED_ONE << idx_new;
               mole_d = '0;
            end else begin
               mole_d = mole_q + MOLE_W'(1);
            end
            if (sec_wrap) begin
               sec_d  = '0;
               time_d = time_q - 8'd1;
               // Final second: the game ends here, but a hit on this edge is already counted.
               if (time_q == 8'd1) begin
                  state_d = OVER;
                  led_d   = '0;
               end
            end else begin
               sec_d = sec_q + SEC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign LED       = led_q;
   assign score     = score_q;
   assign time_left = time_q;
   assign playing   = playing_q;
   assign game_over = over_q;

endmodule
